// File: rtl/w_stage_grf.sv
// ---------------------------------------------------------------------------
// w_stage_grf
// Consumer end of the W-stage pipeline register. Decodes the destination
// register and write-back source of the instruction sitting in W, commits the
// result into a 32x32 general register file, and serves two combinational
// read ports to the D stage with a W->D bypass. Also keeps a retire counter
// and a one-cycle registered write trace.
//
// Ports:
//   clk, reset          rising-edge clock, asynchronous active-high reset
//   we                  W stage holds a valid instruction this cycle
//   w_instr/w_pc        W-stage instruction and PC
//   w_alu/w_dm          W-stage ALU result and data-memory read data
//   rs_addr/rt_addr     D-stage read addresses
//   rs_data/rt_data     D-stage read data (bypassed from W when applicable)
//   trace_valid         a register write committed on the previous edge
//   trace_pc/addr/data  PC, destination and data of that committed write
//   retire_cnt          count of retired non-bubble instructions
// ---------------------------------------------------------------------------
module w_stage_grf #(
    parameter int          CNT_W       = 32,
    parameter logic [31:0] LINK_OFFSET = 32'd8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             we,
    input  logic [31:0]      w_instr,
    input  logic [31:0]      w_pc,
    input  logic [31:0]      w_alu,
    input  logic [31:0]      w_dm,
    input  logic [4:0]       rs_addr,
    input  logic [4:0]       rt_addr,
    output logic [31:0]      rs_data,
    output logic [31:0]      rt_data,
    output logic             trace_valid,
    output logic [31:0]      trace_pc,
    output logic [4:0]       trace_addr,
    output logic [31:0]      trace_data,
    output logic [CNT_W-1:0] retire_cnt
);

    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_JAL     = 6'h03;
    localparam logic [5:0] OP_ORI     = 6'h0d;
    localparam logic [5:0] OP_LUI     = 6'h0f;
    localparam logic [5:0] OP_LW      = 6'h23;
    localparam logic [5:0] FN_JR      = 6'h08;
    localparam logic [5:0] FN_JALR    = 6'h09;

    logic [5:0]  op;
    logic [5:0]  funct;
    logic        dec_write;
    logic [4:0]  dst;
    logic [31:0] wr_data;
    logic [31:0] link_addr;
    logic        wr_en;

    logic [31:0] regs [32];

    assign op        = w_instr[31:26];
    assign funct     = w_instr[5:0];
    assign link_addr = w_pc + LINK_OFFSET;

    // Destination and write-back source decode for the instruction in W.
    always_comb begin
        dec_write = 1'b0;
        dst       = 5'd0;
        wr_data   = w_alu;
        case (op)
            OP_SPECIAL: begin
                if (funct != FN_JR) begin
                    dec_write = 1'b1;
                    dst       = w_instr[15:11];
                    wr_data   = (funct == FN_JALR) ? link_addr : w_alu;
                end
            end
            OP_ORI, OP_LUI: begin
                dec_write = 1'b1;
                dst       = w_instr[20:16];
                wr_data   = w_alu;
            end
            OP_LW: begin
                dec_write = 1'b1;
                dst       = w_instr[20:16];
                wr_data   = w_dm;
            end
            OP_JAL: begin
                dec_write = 1'b1;
                dst       = 5'd31;
                wr_data   = link_addr;
            end
            default: begin
                dec_write = 1'b0;
            end
        endcase
    end

    // $0 is hardwired, so a $0-destined write is treated as no write at all
    // (no commit, no bypass, no trace pulse).
    assign wr_en = we & dec_write & (dst != 5'd0);

    // Register file storage; entry 0 is cleared on reset and never written.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= 32'd0;
            end
        end else if (wr_en) begin
            regs[dst] <= wr_data;
        end
    end

    // Read ports: $0 first, then the same-cycle bypass, then storage.
    always_comb begin
        rs_data = regs[rs_addr];
        if (rs_addr == 5'd0) begin
            rs_data = 32'd0;
        end else if (wr_en && (rs_addr == dst)) begin
            rs_data = wr_data;
        end
    end

    always_comb begin
        rt_data = regs[rt_addr];
        if (rt_addr == 5'd0) begin
            rt_data = 32'd0;
        end else if (wr_en && (rt_addr == dst)) begin
            rt_data = wr_data;
        end
    end

    // Write trace: pulses for one cycle per commit, payload holds otherwise.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            trace_valid <= 1'b0;
            trace_pc    <= 32'd0;
            trace_addr  <= 5'd0;
            trace_data  <= 32'd0;
        end else begin
            trace_valid <= wr_en;
            if (wr_en) begin
                trace_pc   <= w_pc;
                trace_addr <= dst;
                trace_data <= wr_data;
            end
        end
    end

    // Retire counter: every valid non-bubble instruction counts, including
    // ones that do not write a register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            retire_cnt <= '0;
        end else if (we && (w_instr != 32'd0)) begin
            retire_cnt <= retire_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_w_stage_grf.sv
// ---------------------------------------------------------------------------
// tb_w_stage_grf
// Self-checking bench for w_stage_grf: directed scenarios with literal
// expectations followed by randomized instruction streams checked every
// cycle against a behavioural register-file model.
// ---------------------------------------------------------------------------
module tb_w_stage_grf;

    logic        clk;
    logic        reset;
    logic        we;
    logic [31:0] w_instr;
    logic [31:0] w_pc;
    logic [31:0] w_alu;
    logic [31:0] w_dm;
    logic [4:0]  rs_addr;
    logic [4:0]  rt_addr;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        trace_valid;
    logic [31:0] trace_pc;
    logic [4:0]  trace_addr;
    logic [31:0] trace_data;
    logic [31:0] retire_cnt;

    int checks = 0;
    int fails  = 0;

    // Behavioural model state
    logic [31:0] m_regs [32];
    logic        m_tv;
    logic [31:0] m_tpc;
    logic [4:0]  m_taddr;
    logic [31:0] m_tdata;
    logic [31:0] m_cnt;

    w_stage_grf dut (
        .clk         (clk),
        .reset       (reset),
        .we          (we),
        .w_instr     (w_instr),
        .w_pc        (w_pc),
        .w_alu       (w_alu),
        .w_dm        (w_dm),
        .rs_addr     (rs_addr),
        .rt_addr     (rt_addr),
        .rs_data     (rs_data),
        .rt_data     (rt_data),
        .trace_valid (trace_valid),
        .trace_pc    (trace_pc),
        .trace_addr  (trace_addr),
        .trace_data  (trace_data),
        .retire_cnt  (retire_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: actual=%h expected=%h at t=%0t", name, act, exp, $time);
        end
    endtask

    // What the instruction in W architecturally writes, if anything.
    task automatic modelWrite(output bit does, output logic [4:0] d, output logic [31:0] v);
        logic [5:0] o;
        logic [5:0] f;
        o = w_instr[31:26];
        f = w_instr[5:0];
        does = 1'b0;
        d    = 5'd0;
        v    = 32'd0;
        if (o == 6'h00 && f == 6'h09) begin
            does = 1'b1; d = w_instr[15:11]; v = w_pc + 32'd8;
        end else if (o == 6'h00 && f != 6'h08) begin
            does = 1'b1; d = w_instr[15:11]; v = w_alu;
        end else if (o == 6'h0d || o == 6'h0f) begin
            does = 1'b1; d = w_instr[20:16]; v = w_alu;
        end else if (o == 6'h23) begin
            does = 1'b1; d = w_instr[20:16]; v = w_dm;
        end else if (o == 6'h03) begin
            does = 1'b1; d = 5'd31; v = w_pc + 32'd8;
        end
        if (!we || d == 5'd0) does = 1'b0;
    endtask

    function automatic logic [31:0] modelRead(input logic [4:0] a, input bit does,
                                              input logic [4:0] d, input logic [31:0] v);
        if (a == 5'd0) return 32'd0;
        if (does && a == d) return v;
        return m_regs[a];
    endfunction

    task automatic modelReset();
        for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
        m_tv = 1'b0; m_tpc = 32'd0; m_taddr = 5'd0; m_tdata = 32'd0; m_cnt = 32'd0;
    endtask

    // Compare every DUT output against the model for the current cycle.
    task automatic checkOutput();
        bit          does;
        logic [4:0]  d;
        logic [31:0] v;
        modelWrite(does, d, v);
        check32("rs_data", rs_data, modelRead(rs_addr, does, d, v));
        check32("rt_data", rt_data, modelRead(rt_addr, does, d, v));
        check32("trace_valid", {31'd0, trace_valid}, {31'd0, m_tv});
        check32("trace_pc", trace_pc, m_tpc);
        check32("trace_addr", {27'd0, trace_addr}, {27'd0, m_taddr});
        check32("trace_data", trace_data, m_tdata);
        check32("retire_cnt", retire_cnt, m_cnt);
    endtask

    task automatic modelEdge();
        bit          does;
        logic [4:0]  d;
        logic [31:0] v;
        modelWrite(does, d, v);
        if (does) begin
            m_regs[d] = v;
            m_tpc = w_pc; m_taddr = d; m_tdata = v;
        end
        m_tv = does;
        if (we && w_instr != 32'd0) m_cnt = m_cnt + 32'd1;
    endtask

    task automatic applyStimulus(input logic e, input logic [31:0] ins, input logic [31:0] pc,
                                 input logic [31:0] alu, input logic [31:0] dm,
                                 input logic [4:0] ra, input logic [4:0] rb);
        @(negedge clk);
        we = e; w_instr = ins; w_pc = pc; w_alu = alu; w_dm = dm;
        rs_addr = ra; rt_addr = rb;
    endtask

    // Check the settled cycle, cross the edge, leave time just past the edge.
    task automatic step();
        #1;
        checkOutput();
        @(posedge clk);
        modelEdge();
        #1;
    endtask

    function automatic logic [31:0] randInstr();
        logic [31:0] b;
        b = $urandom();
        case ($urandom_range(0, 11))
            0:  return {6'h00, b[25:6], 6'h21};
            1:  return {6'h00, b[25:6], 6'h08};
            2:  return {6'h00, b[25:6], 6'h09};
            3:  return {6'h0d, b[25:0]};
            4:  return {6'h0f, b[25:0]};
            5:  return {6'h23, b[25:0]};
            6:  return {6'h03, b[25:0]};
            7:  return {6'h04, b[25:0]};
            8:  return {6'h2b, b[25:0]};
            9:  return {6'h02, b[25:0]};
            10: return 32'd0;
            default: return b;
        endcase
    endfunction

    function automatic logic [4:0] pickAddr(input logic [31:0] ins);
        logic [4:0] r;
        r = 5'($urandom_range(0, 31));
        case ($urandom_range(0, 3))
            0: return ins[15:11];
            1: return ins[20:16];
            2: return 5'd31;
            default: return r;
        endcase
    endfunction

    initial begin
        logic [31:0] ins;
        reset = 1'b1; we = 1'b0; w_instr = 32'd0; w_pc = 32'd0;
        w_alu = 32'd0; w_dm = 32'd0; rs_addr = 5'd5; rt_addr = 5'd0;
        modelReset();
        #12;
        check32("reset_rs5", rs_data, 32'd0);
        check32("reset_cnt", retire_cnt, 32'd0);
        check32("reset_tv", {31'd0, trace_valid}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // lui $8: bypass visible before the edge, committed after it
        applyStimulus(1'b1, 32'h3c080001, 32'h00003000, 32'h00010000, 32'd0, 5'd5, 5'd8);
        #1;
        check32("lui_bypass", rt_data, 32'h00010000);
        step();
        check32("lui_tv", {31'd0, trace_valid}, 32'd1);
        check32("lui_taddr", {27'd0, trace_addr}, 32'd8);
        check32("lui_cnt", retire_cnt, 32'd1);
        applyStimulus(1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 5'd8, 5'd8);
        #1;
        check32("lui_reg8", rs_data, 32'h00010000);
        step();

        // jal: link address into $31
        applyStimulus(1'b1, 32'h0c000c00, 32'h00003004, 32'h0, 32'h0, 5'd31, 5'd0);
        step();
        check32("jal_tpc", trace_pc, 32'h00003004);
        check32("jal_tdata", trace_data, 32'h0000300c);
        applyStimulus(1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 5'd31, 5'd0);
        #1;
        check32("jal_reg31", rs_data, 32'h0000300c);
        step();

        // lw $9 takes memory data, not the address
        applyStimulus(1'b1, 32'h8c090000, 32'h00003008, 32'h4, 32'hdeadbeef, 5'd9, 5'd9);
        step();
        applyStimulus(1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 5'd9, 5'd0);
        #1;
        check32("lw_reg9", rs_data, 32'hdeadbeef);
        step();

        // addu $0 retires without writing; a bubble does not retire
        applyStimulus(1'b1, 32'h00000021, 32'h0000300c, 32'h1234, 32'h0, 5'd0, 5'd0);
        #1;
        check32("addu0_read", rs_data, 32'd0);
        step();
        check32("addu0_tv", {31'd0, trace_valid}, 32'd0);
        check32("addu0_cnt", retire_cnt, 32'd4);
        applyStimulus(1'b1, 32'd0, 32'h00003010, 32'h55, 32'h0, 5'd0, 5'd0);
        step();
        check32("bubble_cnt", retire_cnt, 32'd4);

        // we=0 ori: ignored; sw/beq retire without writing
        applyStimulus(1'b0, 32'h34030005, 32'h00003014, 32'h5, 32'h0, 5'd3, 5'd3);
        step();
        check32("we0_cnt", retire_cnt, 32'd4);
        applyStimulus(1'b1, 32'hac030000, 32'h00003018, 32'h8, 32'h0, 5'd3, 5'd0);
        #1;
        check32("we0_reg3", rs_data, 32'd0);
        step();
        applyStimulus(1'b1, 32'h10000000, 32'h0000301c, 32'h0, 32'h0, 5'd3, 5'd0);
        step();
        check32("beq_tv", {31'd0, trace_valid}, 32'd0);
        check32("beq_cnt", retire_cnt, 32'd6);

        // Mid-cycle reset with a write pending to $9 while reading $8
        applyStimulus(1'b1, 32'h34090077, 32'h00003020, 32'h77, 32'h0, 5'd8, 5'd9);
        #2;
        reset = 1'b1;
        #1;
        check32("midrst_reg8", rs_data, 32'd0);
        check32("midrst_cnt", retire_cnt, 32'd0);
        check32("midrst_tv", {31'd0, trace_valid}, 32'd0);
        modelReset();
        @(posedge clk);
        #1;
        reset = 1'b0;
        applyStimulus(1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 5'd9, 5'd8);
        #1;
        check32("midrst_reg9", rs_data, 32'd0);
        step();

        // Randomized stream against the model
        for (int n = 0; n < 600; n++) begin
            ins = randInstr();
            applyStimulus(($urandom_range(0, 3) != 0), ins, $urandom(), $urandom(), $urandom(),
                          pickAddr(ins), pickAddr(ins));
            step();
        end
        applyStimulus(1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 5'd1, 5'd2);
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
